// File: rtl/multicycle_shifter_if.sv
// ---------------------------------------------------------------------------
// multicycle_shifter_if
//   Handshake and data bundle between the execute-stage sequencer (master)
//   and the multi-cycle shifter (slave).
//
//   Parameters:
//     WIDTH - operand/result width in bits (>= 2)
//     CNT_W - width of the shift-count field
//
//   Signals (named from the shifter's point of view):
//     i_start  - operation request, sampled only while the shifter is idle
//     i_data   - operand, latched when the request is accepted
//     i_count  - number of single-bit steps, latched when accepted
//     i_rotate - 1 = rotate through carry, 0 = plain shift
//     i_right  - 1 = shift right, 0 = shift left
//     i_arith  - arithmetic right-shift select (only honoured when the
//                shifter is built with SHIFTER_ASR_EN)
//     i_c      - carry-in, latched when accepted
//     o_busy   - shifter is not idle
//     o_done   - one-cycle completion pulse
//     o_data   - result register
//     o_n      - o_data MSB
//     o_z      - o_data is all zeros
//     o_c      - carry register (last bit shifted out)
// ---------------------------------------------------------------------------
interface multicycle_shifter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             i_start;
    logic [WIDTH-1:0] i_data;
    logic [CNT_W-1:0] i_count;
    logic             i_rotate;
    logic             i_right;
    logic             i_arith;
    logic             i_c;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_data;
    logic             o_n;
    logic             o_z;
    logic             o_c;

    modport master (
        output i_start, i_data, i_count, i_rotate, i_right, i_arith, i_c,
        input  o_busy, o_done, o_data, o_n, o_z, o_c
    );

    modport slave (
        input  i_start, i_data, i_count, i_rotate, i_right, i_arith, i_c,
        output o_busy, o_done, o_data, o_n, o_z, o_c
    );
endinterface

// File: rtl/multicycle_shifter.sv
// ---------------------------------------------------------------------------
// multicycle_shifter
//   Shifts or rotates a WIDTH-bit operand by a run-time count, one bit
//   position per clock, producing 6502-compatible N/Z/C flags
//   (ASL/LSR/ROL/ROR). Rotation goes through the carry, i.e. it is a
//   WIDTH+1-bit rotation. Counts above WIDTH are executed step by step
//   without any reduction.
//
//   Optional feature macro: SHIFTER_ASR_EN
//     defined   - i_arith is honoured; non-rotate right shifts replicate
//                 the MSB.
//     undefined - i_arith is ignored; right shifts fill with zero. The port
//                 remains so both builds instantiate identically.
//
//   Ports:
//     i_clk - clock, all state changes on the rising edge
//     i_rst - asynchronous active-high reset, aborts any operation
//     bus   - multicycle_shifter_if.slave (start/busy/done handshake,
//             operand, mode bits, result and flags)
//
//   Timing: a count k accepted at edge E gives o_done high between edges
//   E+k and E+k+1; o_busy is high from E to E+k+1.
// ---------------------------------------------------------------------------
module multicycle_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    multicycle_shifter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] data_r;
    logic             c_r;
    logic [CNT_W-1:0] rem_r;
    logic             rotate_r;
    logic             right_r;
    logic             arith_r;
    logic             arith_s;

    logic [WIDTH-1:0] step_data_s;
    logic             step_c_s;
    logic             fill_s;
    logic             accept_s;
    logic             busy_s;
    logic             done_s;

    // A request is only seen while idle; anything arriving later is dropped.
    assign accept_s = (state_r == ST_IDLE) && bus.i_start;

`ifdef SHIFTER_ASR_EN
    assign arith_s = arith_r;
`else
    // Without the arithmetic option the latched select is forced low.
    assign arith_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_count == CNT_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // rem_r counts the steps still to run, including this edge.
                if (rem_r == CNT_ONE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_SHIFT: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // One single-bit step of the datapath; rotate takes priority over arith.
    always_comb begin
        fill_s      = 1'b0;
        step_data_s = data_r;
        step_c_s    = c_r;
        if (right_r) begin
            if (rotate_r) begin
                fill_s = c_r;
            end else if (arith_s) begin
                fill_s = data_r[WIDTH-1];
            end else begin
                fill_s = 1'b0;
            end
            step_c_s    = data_r[0];
            step_data_s = {fill_s, data_r[WIDTH-1:1]};
        end else begin
            if (rotate_r) begin
                fill_s = c_r;
            end else begin
                fill_s = 1'b0;
            end
            step_c_s    = data_r[WIDTH-1];
            step_data_s = {data_r[WIDTH-2:0], fill_s};
        end
    end

    // Operand/mode capture on accept, stepping in SHIFT, hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_r   <= {WIDTH{1'b0}};
            c_r      <= 1'b0;
            rem_r    <= CNT_ZERO;
            rotate_r <= 1'b0;
            right_r  <= 1'b0;
            arith_r  <= 1'b0;
        end else if (accept_s) begin
            data_r   <= bus.i_data;
            c_r      <= bus.i_c;
            rem_r    <= bus.i_count;
            rotate_r <= bus.i_rotate;
            right_r  <= bus.i_right;
            arith_r  <= bus.i_arith;
        end else if (state_r == ST_SHIFT) begin
            data_r   <= step_data_s;
            c_r      <= step_c_s;
            rem_r    <= rem_r - CNT_ONE;
        end else begin
            data_r   <= data_r;
            c_r      <= c_r;
            rem_r    <= rem_r;
        end
    end

`ifndef SHIFTER_ASR_EN
    // arith_r is captured but has no consumer in this build.
    logic unused_arith_s;
    assign unused_arith_s = arith_r;
`endif

    assign bus.o_busy = busy_s;
    assign bus.o_done = done_s;
    assign bus.o_data = data_r;
    assign bus.o_c    = c_r;
    assign bus.o_n    = data_r[WIDTH-1];
    assign bus.o_z    = (data_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_multicycle_shifter.sv
// ---------------------------------------------------------------------------
// tb_multicycle_shifter
//   Directed, table-driven bench for multicycle_shifter (WIDTH=8, CNT_W=4)
//   with hand-written sequences for the ignored-start and mid-operation
//   reset cases. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_multicycle_shifter;

    logic clk;
    logic rst;

    int checks;
    int failures;

    multicycle_shifter_if #(.WIDTH(8), .CNT_W(4)) bus ();

    multicycle_shifter #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       c;
        logic [3:0] count;
        logic       rotate;
        logic       right;
        logic       arith;
        logic [7:0] exp_data;
        logic       exp_c;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_start  = 1'b0;
        bus.i_data   = 8'h00;
        bus.i_count  = 4'd0;
        bus.i_rotate = 1'b0;
        bus.i_right  = 1'b0;
        bus.i_arith  = 1'b0;
        bus.i_c      = 1'b0;
    endtask

    task automatic drive_op(input vec_t v);
        bus.i_start  = 1'b1;
        bus.i_data   = v.data;
        bus.i_count  = v.count;
        bus.i_rotate = v.rotate;
        bus.i_right  = v.right;
        bus.i_arith  = v.arith;
        bus.i_c      = v.c;
    endtask

    // Launch one operation and check busy/done timing, result and flags.
    task automatic run_vec(input vec_t v, input string tag);
        bit timing_ok;
        logic [7:0] d_at_done;
        logic c_at_done, n_at_done, z_at_done;
        timing_ok = 1'b1;
        d_at_done = 8'h00;
        c_at_done = 1'b0;
        n_at_done = 1'b0;
        z_at_done = 1'b0;
        @(negedge clk);
        drive_op(v);
        @(posedge clk);            // edge E
        #1;
        bus.i_start = 1'b0;
        for (int i = 0; i <= int'(v.count); i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.o_busy !== 1'b1) timing_ok = 1'b0;
            if (bus.o_done !== (i == int'(v.count))) timing_ok = 1'b0;
            if (i == int'(v.count)) begin
                d_at_done = bus.o_data;
                c_at_done = bus.o_c;
                n_at_done = bus.o_n;
                z_at_done = bus.o_z;
            end
        end
        check({tag, "_timing"}, {31'd0, timing_ok}, 32'd1);
        check({tag, "_data"}, {24'd0, d_at_done}, {24'd0, v.exp_data});
        check({tag, "_c"}, {31'd0, c_at_done}, {31'd0, v.exp_c});
        check({tag, "_n"}, {31'd0, n_at_done}, {31'd0, v.exp_data[7]});
        check({tag, "_z"}, {31'd0, z_at_done}, {31'd0, (v.exp_data == 8'h00)});
        @(posedge clk);            // edge E+k+1
        #1;
        check({tag, "_idle"}, {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        check({tag, "_hold"}, {23'd0, bus.o_c, bus.o_data}, {23'd0, v.exp_c, v.exp_data});
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //             data   c     cnt   rot   rgt   ari   exp     exp_c
        vecs[0] = '{8'h41, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 8'h82, 1'b0}; // ASL
        vecs[1] = '{8'h80, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 8'h80, 1'b1}; // ROL full period
        vecs[2] = '{8'h01, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 8'h00, 1'b1}; // LSR to zero
        vecs[3] = '{8'h80, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 8'h80, 1'b0}; // ROR count 0
`ifdef SHIFTER_ASR_EN
        vecs[4] = '{8'h80, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 8'hF0, 1'b0}; // ASR
`else
        vecs[4] = '{8'h80, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 8'h10, 1'b0}; // arith ignored
`endif
        vecs[5] = '{8'hFF, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1}; // ASL by WIDTH
        vecs[6] = '{8'h01, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 8'h80, 1'b0}; // ROR via carry
        vecs[7] = '{8'hA5, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}; // LSR count > WIDTH
        vecs[8] = '{8'h5A, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 8'hA2, 1'b1}; // ROL 4
        vecs[9] = '{8'h80, 1'b0, 4'd1,  1'b1, 1'b1, 1'b1, 8'h40, 1'b0}; // rotate beats arith

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        check("reset_data", {24'd0, bus.o_data}, 32'h00);
        check("reset_flags", {29'd0, bus.o_n, bus.o_z, bus.o_c}, 32'b010);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // A start pulse while SHIFT is running must be dropped.
        begin
            int  done_cycle;
            vec_t bogus;
            bogus = '{8'hFF, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
            done_cycle = -1;
            @(negedge clk);
            drive_op(vecs[8]);
            @(posedge clk);        // edge E
            #1;
            bus.i_start = 1'b0;
            @(negedge clk);
            drive_op(bogus);
            @(posedge clk);        // edge E+1
            #1;
            drive_idle();
            if (bus.o_done === 1'b1) done_cycle = 1;
            for (int cyc = 2; cyc <= 20 && done_cycle < 0; cyc++) begin
                @(posedge clk);
                #1;
                if (bus.o_done === 1'b1) done_cycle = cyc;
            end
            check("ignored_start_done_cycle", done_cycle, 32'd4);
            check("ignored_start_data", {23'd0, bus.o_c, bus.o_data}, {23'd0, 1'b1, 8'hA2});
            @(posedge clk);
            #1;
            check("ignored_start_no_queue", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        end

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        drive_op(vecs[5]);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        check("midrst_data", {24'd0, bus.o_data}, 32'h00);
        check("midrst_flags", {29'd0, bus.o_n, bus.o_z, bus.o_c}, 32'b010);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
